// File: rtl/regfile_result_checker_pkg.sv
//------------------------------------------------------------------------------
// checker_pkg
// Shared types and constants for the register-file result checker:
//   - chk_state_e   : checker FSM state encoding
//   - DEF_*         : default widths/depth used by the interface and the top
//   - CHK_CYCLE_MIN : smallest effective check cycle (a programmed 0 maps here)
//   - calc_idx_w()  : table index width, never narrower than one bit
//------------------------------------------------------------------------------
package checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_SCAN  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } chk_state_e;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_ADDR_W     = 5;
   localparam int DEF_NUM_CHECKS = 8;
   localparam int DEF_CYCLE_W    = 16;
   localparam int CHK_CYCLE_MIN  = 1;

   // A single-entry table still needs a 1-bit index.
   function automatic int calc_idx_w(input int num_checks);
      if (num_checks > 1) begin
         return $clog2(num_checks);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/regfile_result_checker_if.sv
//------------------------------------------------------------------------------
// regfile_result_checker_if
// Bundles the checker's control, expected-table write, register-file read
// port and result signals.
//   master : the controller side (drives start/table writes, returns rf_rdata)
//   slave  : the checker itself
// Signals:
//   start, check_cycle            run control
//   exp_we, exp_idx, exp_addr,    expected-table write port
//   exp_data
//   rf_raddr / rf_rdata           dedicated register-file read port
//   busy, done, pass,             results
//   mismatch_count, checked_count,
//   fail_idx, halt_req
//------------------------------------------------------------------------------
interface regfile_result_checker_if
   import checker_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int NUM_CHECKS = DEF_NUM_CHECKS,
   parameter int CYCLE_W    = DEF_CYCLE_W
);
   localparam int IDX_W = calc_idx_w(NUM_CHECKS);

   logic               start;
   logic [CYCLE_W-1:0] check_cycle;
   logic               exp_we;
   logic [IDX_W-1:0]   exp_idx;
   logic [ADDR_W-1:0]  exp_addr;
   logic [DATA_W-1:0]  exp_data;
   logic [ADDR_W-1:0]  rf_raddr;
   logic [DATA_W-1:0]  rf_rdata;
   logic               busy;
   logic               done;
   logic               pass;
   logic [IDX_W:0]     mismatch_count;
   logic [IDX_W:0]     checked_count;
   logic [IDX_W-1:0]   fail_idx;
   logic               halt_req;

   modport master (
      output start, check_cycle, exp_we, exp_idx, exp_addr, exp_data, rf_rdata,
      input  rf_raddr, busy, done, pass, mismatch_count, checked_count,
             fail_idx, halt_req
   );

   modport slave (
      input  start, check_cycle, exp_we, exp_idx, exp_addr, exp_data, rf_rdata,
      output rf_raddr, busy, done, pass, mismatch_count, checked_count,
             fail_idx, halt_req
   );

endinterface

// File: rtl/regfile_result_checker_expect_table.sv
//------------------------------------------------------------------------------
// regfile_expect_table
// Storage for the expected-result table: one {valid, addr, data} per entry.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_we/i_wr_idx/i_wr_addr/    write port (sets valid, last write wins)
//   i_wr_data
//   i_rd_idx -> o_rd_valid,     combinational read of the entry being compared
//               o_rd_data
//   i_pf_idx -> o_pf_addr       combinational read of the register index to
//                               present on the register-file port next cycle
// Out-of-range indices (non power-of-two depth) read as invalid and are not
// written.
//------------------------------------------------------------------------------
module regfile_expect_table #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int NUM_CHECKS = 8,
   parameter int IDX_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic [IDX_W-1:0]  i_pf_idx,
   output logic [ADDR_W-1:0] o_pf_addr
);

   logic [NUM_CHECKS-1:0] r_valid;
   logic [ADDR_W-1:0]     r_addr [NUM_CHECKS];
   logic [DATA_W-1:0]     r_data [NUM_CHECKS];
   logic                  w_wr_ok;

   assign w_wr_ok = i_we && (int'(i_wr_idx) < NUM_CHECKS);

   // Table storage: reset clears every entry, a write validates one entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            r_valid[i] <= 1'b0;
            r_addr[i]  <= {ADDR_W{1'b0}};
            r_data[i]  <= {DATA_W{1'b0}};
         end
      end else if (w_wr_ok) begin
         r_valid[i_wr_idx] <= 1'b1;
         r_addr[i_wr_idx]  <= i_wr_addr;
         r_data[i_wr_idx]  <= i_wr_data;
      end
   end

   // Compare-side read: validity and expected value of the scanned entry.
   always_comb begin
      o_rd_valid = 1'b0;
      o_rd_data  = {DATA_W{1'b0}};
      if (int'(i_rd_idx) < NUM_CHECKS) begin
         o_rd_valid = r_valid[i_rd_idx];
         o_rd_data  = r_data[i_rd_idx];
      end else begin
         o_rd_valid = 1'b0;
         o_rd_data  = {DATA_W{1'b0}};
      end
   end

   // Address-side read: register index for the upcoming scan slot.
   always_comb begin
      o_pf_addr = {ADDR_W{1'b0}};
      if (int'(i_pf_idx) < NUM_CHECKS) begin
         o_pf_addr = r_addr[i_pf_idx];
      end else begin
         o_pf_addr = {ADDR_W{1'b0}};
      end
   end

endmodule

// File: rtl/regfile_result_checker.sv
//------------------------------------------------------------------------------
// regfile_result_checker
// End-of-run result monitor. After a programmed number of cycles from start it
// walks the expected table, reading each listed register through a dedicated
// register-file read port, and reports pass/fail, the number of mismatches,
// the number of entries compared and the first failing entry. A one-cycle
// halt request is raised as results become valid.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset (also clears the table)
//   chk_bus  regfile_result_checker_if.slave (control, table write, RF read
//            port, results)
// Optional build macro:
//   REGFILE_CHECKER_TRACE_EN  simulation-only trace of each compared entry and
//                             of the final result; port behaviour unchanged.
// Scan pipeline: rf_raddr is loaded one cycle ahead, rf_rdata is captured with
// the entry's expected value on the scan edge, and the comparison retires on
// the following edge (the last one during DRAIN).
//------------------------------------------------------------------------------
module regfile_result_checker
   import checker_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int NUM_CHECKS = DEF_NUM_CHECKS,
   parameter int CYCLE_W    = DEF_CYCLE_W
) (
   input logic                    clk,
   input logic                    rst,
   regfile_result_checker_if.slave chk_bus
);

   localparam int IDX_W = calc_idx_w(NUM_CHECKS);
   localparam int CNT_W = IDX_W + 1;

   chk_state_e         r_state;
   logic [CYCLE_W-1:0] r_cycle_tgt;
   logic [CYCLE_W-1:0] r_counter;
   logic [IDX_W-1:0]   r_idx;
   logic [ADDR_W-1:0]  r_raddr;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic               r_halt;
   logic [CNT_W-1:0]   r_mm_cnt;
   logic [CNT_W-1:0]   r_chk_cnt;
   logic [IDX_W-1:0]   r_fail_idx;
   logic               r_cmp_vld;
   logic               r_cmp_ent_vld;
   logic [DATA_W-1:0]  r_cmp_got;
   logic [DATA_W-1:0]  r_cmp_exp;
   logic [IDX_W-1:0]   r_cmp_idx;

   logic               w_tbl_we;
   logic [IDX_W-1:0]   w_pf_idx;
   logic [ADDR_W-1:0]  w_pf_addr;
   logic               w_rd_valid;
   logic [DATA_W-1:0]  w_rd_data;
   logic               w_cmp_hit;
   logic               w_cmp_bad;
   logic [CNT_W-1:0]   w_mm_next;
   logic [CNT_W-1:0]   w_chk_next;
   logic               w_idx_last;
   logic [CYCLE_W-1:0] w_cc_eff;
   logic               w_cnt_sat;

   regfile_expect_table #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .NUM_CHECKS (NUM_CHECKS),
      .IDX_W      (IDX_W)
   ) u_table (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_tbl_we),
      .i_wr_idx   (chk_bus.exp_idx),
      .i_wr_addr  (chk_bus.exp_addr),
      .i_wr_data  (chk_bus.exp_data),
      .i_rd_idx   (r_idx),
      .o_rd_valid (w_rd_valid),
      .o_rd_data  (w_rd_data),
      .i_pf_idx   (w_pf_idx),
      .o_pf_addr  (w_pf_addr)
   );

   // Table writes are only accepted while no scan is walking the table.
   always_comb begin
      w_tbl_we = 1'b0;
      case (r_state)
         ST_IDLE, ST_COUNT, ST_DONE: w_tbl_we = chk_bus.exp_we;
         default:                    w_tbl_we = 1'b0;
      endcase
   end

   // Entry whose address goes onto rf_raddr at the next edge: entry 0 when
   // leaving COUNT, otherwise the entry after the one being scanned.
   always_comb begin
      w_pf_idx = {IDX_W{1'b0}};
      if (r_state == ST_SCAN) begin
         w_pf_idx = r_idx + IDX_W'(1);
      end else begin
         w_pf_idx = {IDX_W{1'b0}};
      end
   end

   // Compare retirement and helper decodes.
   always_comb begin
      w_cmp_hit  = r_cmp_vld & r_cmp_ent_vld;
      w_cmp_bad  = w_cmp_hit & (r_cmp_got != r_cmp_exp);
      w_chk_next = r_chk_cnt + (w_cmp_hit ? CNT_W'(1) : CNT_W'(0));
      w_mm_next  = r_mm_cnt  + (w_cmp_bad ? CNT_W'(1) : CNT_W'(0));
      w_idx_last = (r_idx == IDX_W'(NUM_CHECKS - 1));
      w_cnt_sat  = (r_counter == {CYCLE_W{1'b1}});
      w_cc_eff   = (chk_bus.check_cycle < CYCLE_W'(CHK_CYCLE_MIN)) ?
                   CYCLE_W'(CHK_CYCLE_MIN) : chk_bus.check_cycle;
   end

   // Checker FSM, cycle counter, compare pipeline and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cycle_tgt   <= CYCLE_W'(CHK_CYCLE_MIN);
         r_counter     <= {CYCLE_W{1'b0}};
         r_idx         <= {IDX_W{1'b0}};
         r_raddr       <= {ADDR_W{1'b0}};
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_halt        <= 1'b0;
         r_mm_cnt      <= {CNT_W{1'b0}};
         r_chk_cnt     <= {CNT_W{1'b0}};
         r_fail_idx    <= {IDX_W{1'b0}};
         r_cmp_vld     <= 1'b0;
         r_cmp_ent_vld <= 1'b0;
         r_cmp_got     <= {DATA_W{1'b0}};
         r_cmp_exp     <= {DATA_W{1'b0}};
         r_cmp_idx     <= {IDX_W{1'b0}};
      end else begin
         r_halt    <= 1'b0;
         r_cmp_vld <= 1'b0;

         // Retire the previous capture; only valid entries touch the counts.
         r_chk_cnt <= w_chk_next;
         r_mm_cnt  <= w_mm_next;
         if (w_cmp_bad && (r_mm_cnt == {CNT_W{1'b0}})) begin
            r_fail_idx <= r_cmp_idx;
         end

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (chk_bus.start) begin
                  r_cycle_tgt <= w_cc_eff;
                  r_counter   <= CYCLE_W'(1);
                  r_mm_cnt    <= {CNT_W{1'b0}};
                  r_chk_cnt   <= {CNT_W{1'b0}};
                  r_fail_idx  <= {IDX_W{1'b0}};
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_state     <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (r_counter == r_cycle_tgt) begin
                  r_idx   <= {IDX_W{1'b0}};
                  r_raddr <= w_pf_addr;
                  r_state <= ST_SCAN;
               end else if (!w_cnt_sat) begin
                  r_counter <= r_counter + CYCLE_W'(1);
               end
            end
            ST_SCAN: begin
               // rf_rdata already reflects rf_raddr = addr[r_idx].
               r_cmp_vld     <= 1'b1;
               r_cmp_ent_vld <= w_rd_valid;
               r_cmp_got     <= chk_bus.rf_rdata;
               r_cmp_exp     <= w_rd_data;
               r_cmp_idx     <= r_idx;
               if (w_idx_last) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_raddr <= w_pf_addr;
               end
            end
            ST_DRAIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_pass  <= (w_mm_next == {CNT_W{1'b0}});
               r_halt  <= 1'b1;
               r_state <= ST_DONE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign chk_bus.rf_raddr       = r_raddr;
   assign chk_bus.busy           = r_busy;
   assign chk_bus.done           = r_done;
   assign chk_bus.pass           = r_pass;
   assign chk_bus.mismatch_count = r_mm_cnt;
   assign chk_bus.checked_count  = r_chk_cnt;
   assign chk_bus.fail_idx       = r_fail_idx;
   assign chk_bus.halt_req       = r_halt;

`ifdef REGFILE_CHECKER_TRACE_EN
   logic [ADDR_W-1:0] r_trc_addr;

   // Register index that accompanies the entry sitting in the compare stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_trc_addr <= {ADDR_W{1'b0}};
      end else if (r_state == ST_SCAN) begin
         r_trc_addr <= r_raddr;
      end
   end

   // Per-entry trace and end-of-run summary.
   always_ff @(posedge clk) begin
      if (!rst && w_cmp_hit) begin
         $display("regfile_result_checker: x%0d got %0d expected %0d %s",
                  r_trc_addr, r_cmp_got, r_cmp_exp, w_cmp_bad ? "FAIL" : "OK");
      end
      if (!rst && (r_state == ST_DRAIN)) begin
         $display("regfile_result_checker: checked %0d mismatches %0d",
                  w_chk_next, w_mm_next);
      end
   end
`endif

endmodule

// File: tb/tb_regfile_result_checker.sv
//------------------------------------------------------------------------------
// tb_regfile_result_checker
// Directed runs of the result checker against a behavioural register file.
// Each start pushes the hand-computed result into a queue; an independent
// monitor pops and compares whenever halt_req announces results.
//------------------------------------------------------------------------------
module tb_regfile_result_checker;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int NUM_CHECKS = 8;
   localparam int CYCLE_W    = 16;

   typedef struct {
      int t0;
      int lat;
      int pass;
      int mm;
      int chk;
      int fidx;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] tb_rf [32];
   exp_t        exp_q [$];
   int          cyc;
   int          checks;
   int          errors;
   int          issued;
   int          seen;
   logic        prev_halt;

   regfile_result_checker_if #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS), .CYCLE_W(CYCLE_W)
   ) u_if ();

   regfile_result_checker #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS), .CYCLE_W(CYCLE_W)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .chk_bus (u_if.slave)
   );

   assign u_if.rf_rdata = tb_rf[u_if.rf_raddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: results are presented with the single-cycle halt_req pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_halt = 1'b0;
      end else begin
         if (u_if.halt_req) begin
            chk("halt_pulse_len", prev_halt, 0);
            seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=halt required=none");
            end else begin
               e = exp_q.pop_front();
               chk("done_latency", cyc - e.t0, e.lat);
               chk("done", u_if.done, 1);
               chk("busy_at_done", u_if.busy, 0);
               chk("pass", u_if.pass, e.pass);
               chk("mismatch_count", u_if.mismatch_count, e.mm);
               chk("checked_count", u_if.checked_count, e.chk);
               chk("fail_idx", u_if.fail_idx, e.fidx);
            end
         end
         prev_halt = u_if.halt_req;
      end
   end

   task automatic write_entry(input int idx, input int addr, input int data);
      @(negedge clk);
      u_if.exp_we   = 1'b1;
      u_if.exp_idx  = 3'(idx);
      u_if.exp_addr = 5'(addr);
      u_if.exp_data = 32'(data);
      @(negedge clk);
      u_if.exp_we   = 1'b0;
   endtask

   task automatic run_start(input int cc, input bit push, input int lat, input int pass,
                            input int mm, input int nchk, input int fidx, output int t0);
      exp_t e;
      @(negedge clk);
      u_if.check_cycle = 16'(cc);
      u_if.start       = 1'b1;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      t0 = cyc;
      if (push) begin
         e.t0 = t0; e.lat = lat; e.pass = pass; e.mm = mm; e.chk = nchk; e.fidx = fidx;
         exp_q.push_back(e);
         issued++;
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (u_if.done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, (n < budget) ? 1 : 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},     u_if.busy, 0);
      chk({tag, "_done"},     u_if.done, 0);
      chk({tag, "_pass"},     u_if.pass, 0);
      chk({tag, "_mm"},       u_if.mismatch_count, 0);
      chk({tag, "_checked"},  u_if.checked_count, 0);
      chk({tag, "_fail_idx"}, u_if.fail_idx, 0);
      chk({tag, "_halt"},     u_if.halt_req, 0);
      chk({tag, "_raddr"},    u_if.rf_raddr, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      checks = 0; errors = 0; issued = 0; seen = 0; cyc = 0; prev_halt = 1'b0;
      u_if.start = 1'b0; u_if.check_cycle = 16'd0; u_if.exp_we = 1'b0;
      u_if.exp_idx = 3'd0; u_if.exp_addr = 5'd0; u_if.exp_data = 32'd0;
      for (int i = 0; i < 32; i++) tb_rf[i] = 32'h1000 + 32'(i);
      tb_rf[8] = 32'd2; tb_rf[9] = 32'd2; tb_rf[10] = 32'd2;
      tb_rf[11] = 32'd26; tb_rf[12] = 32'd26;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Entries 0-4: regs 8..12 expecting 2,2,2,26,26.
      write_entry(0, 8, 2);  write_entry(1, 9, 2);  write_entry(2, 10, 2);
      write_entry(3, 11, 26); write_entry(4, 12, 26);

      // Run 1: all match; a start pulse during COUNT must be ignored.
      run_start(28, 1'b1, 37, 1, 0, 5, 0, t0);
      repeat (4) @(negedge clk);
      chk("busy_in_count", u_if.busy, 1);
      u_if.start = 1'b1;
      @(negedge clk);
      u_if.start = 1'b0;
      wait_done("run1_timeout", 200);

      // Run 2: reg 11 wrong; restart from DONE clears counts; write in SCAN dropped.
      tb_rf[11] = 32'd25;
      run_start(28, 1'b1, 37, 0, 1, 5, 3, t0);
      chk("restart_done_clr", u_if.done, 0);
      chk("restart_chk_clr", u_if.checked_count, 0);
      while (cyc < t0 + 29) @(negedge clk);
      u_if.exp_we = 1'b1; u_if.exp_idx = 3'd5; u_if.exp_addr = 5'd8; u_if.exp_data = 32'd99;
      @(negedge clk);
      u_if.exp_we = 1'b0;
      wait_done("run2_timeout", 200);

      // Run 3: regs 9 and 12 wrong.
      tb_rf[11] = 32'd26; tb_rf[9] = 32'd7; tb_rf[12] = 32'd0;
      run_start(28, 1'b1, 37, 0, 2, 5, 1, t0);
      wait_done("run3_timeout", 200);

      // Run 4: reset in the middle of SCAN aborts and clears the table.
      run_start(3, 1'b0, 0, 0, 0, 0, 0, t0);
      while (cyc < t0 + 5) @(negedge clk);
      chk("busy_in_scan", u_if.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("abort");
      rst = 1'b0;

      // Run 5: no valid entries, cc=0 behaves as cc=1.
      run_start(0, 1'b1, 10, 1, 0, 0, 0, t0);
      wait_done("run5_timeout", 100);

      // Run 6: last entry mismatches, entry 2 matches reg 0.
      tb_rf[0] = 32'd0; tb_rf[3] = 32'd6;
      write_entry(2, 0, 0);
      write_entry(7, 3, 5);
      run_start(2, 1'b1, 11, 0, 1, 2, 7, t0);
      wait_done("run6_timeout", 100);
      chk("raddr_hold", u_if.rf_raddr, 3);

      repeat (3) @(negedge clk);
      chk("results_seen", seen, issued);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_result_checker.md
# regfile_result_checker

Self-checking result monitor for the pipelined processor. After a programmed number of clock cycles it scans a table of expected register values through a dedicated register-file read port and reports pass/fail, mismatch count and first failing entry. It generalises the fixed-cycle, print-only end-of-program check into a parametrised, synthesizable block with programmable check cycle, check depth and a halt request. It sits beside the register file in `Top` and drives no datapath state.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width
- `NUM_CHECKS`, 8, expected-table depth (≥1)
- `CYCLE_W`, 16, cycle counter width
- `IDX_W`, derived `$clog2(NUM_CHECKS)` (min 1)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin run; latches `check_cycle`
- `check_cycle`  in  CYCLE_W  cycle, counted from start, at which scanning begins; 0 treated as 1
- `exp_we`  in  1  write expected entry
- `exp_idx`  in  IDX_W  table entry written
- `exp_addr`  in  ADDR_W  register index to check
- `exp_data`  in  DATA_W  expected value
- `rf_raddr`  out  ADDR_W  register-file read address
- `rf_rdata`  in  DATA_W  register-file read data, combinational from `rf_raddr`
- `busy`  out  1  run in progress
- `done`  out  1  results valid
- `pass`  out  1  done and zero mismatches
- `mismatch_count`  out  IDX_W+1  failing entries
- `checked_count`  out  IDX_W+1  valid entries compared
- `fail_idx`  out  IDX_W  first failing entry
- `halt_req`  out  1  one-cycle pulse on entering DONE

## Operation
- Table: NUM_CHECKS entries {valid, addr, data}. `exp_we` sets valid and writes addr/data in IDLE, COUNT or DONE; dropped in SCAN and DRAIN. Same entry rewritten: last write wins.
- FSM states IDLE, COUNT, SCAN, DRAIN, DONE.
- IDLE/DONE + `start`: latch `check_cycle` (0→1), counter←1, clear mismatch/checked counts and fail_idx, →COUNT. `start` ignored in COUNT/SCAN/DRAIN.
- COUNT: counter increments; when counter == latched cycle, idx←0, →SCAN. Counter saturates at all-ones (no wrap).
- SCAN: `rf_raddr`←addr[idx]; `rf_rdata` sampled same cycle into a compare stage; next cycle compares against data[idx] if valid. idx increments; after idx = NUM_CHECKS−1 →DRAIN.
- DRAIN: final compare completes; →DONE, pulse `halt_req`.
- Compare: invalid entries skipped (no count change). Mismatch: increments `mismatch_count`; first mismatch records `fail_idx`.
- DONE: outputs held until `start` or `rst`. `pass` = done && mismatch_count == 0 (true with zero valid entries).
- Reset values: state IDLE, all table valid bits 0, `rf_raddr` 0, `busy` 0, `done` 0, `pass` 0, counts 0, `fail_idx` 0, `halt_req` 0.
- `rst` mid-run aborts immediately to IDLE and clears the table.

## Timing
- `start` sampled at edge t0. COUNT during cycles t0..t0+cc−1. SCAN for NUM_CHECKS cycles. One DRAIN cycle. `done` rises at edge t0+cc+NUM_CHECKS+1.
- `busy` high COUNT through DRAIN.
- `halt_req` high exactly the first DONE cycle.
- `rf_raddr` holds last value outside SCAN.

## Configuration
- `REGFILE_CHECKER_TRACE_EN` defined: simulation-only `$display` per valid compared entry (register index, got, expected, OK/FAIL) and a summary line on entering DONE. Undefined: no display code. Port behaviour is identical in both cases.

## Structure
- `checker_pkg`: state enum, default widths, `CHK_CYCLE_MIN` = 1.
- Sub-module `regfile_expect_table`: valid/addr/data storage, write port and indexed read.
- FSM, counter and compare pipeline live in the top module.

## Test plan
- Entries 0–4 = regs 8–12, expected 2,2,2,26,26; RF holds these values; cc=28, N=8 → `done` at t0+37, `pass`=1, `checked_count`=5, `mismatch_count`=0, one `halt_req` pulse.
- Same setup with reg 11 = 25 → `pass`=0, `mismatch_count`=1, `fail_idx`=3.
- Regs 9 and 12 wrong → `mismatch_count`=2, `fail_idx`=1.
- No valid entries, cc=0 → COUNT lasts 1 cycle, `done` at t0+10, `pass`=1, `checked_count`=0.
- `rst` asserted during SCAN → next cycle IDLE, all outputs at reset values. A new `start` with no rewrites → `checked_count`=0.
- `start` pulsed during COUNT, and `exp_we` during SCAN → both ignored, results unchanged. Re-`start` from DONE → counts cleared and run repeats.
